sprite_blitter: RTL and testbench

- Parametrised rectangle drawer for the 160x120 VGA adapter path. It replaces the fixed full-screen background counter and the fixed 8x8 block counter with one engine.
- On a start pulse it walks an SPR_W x SPR_H region anchored at (x0,y0) in row-major order. It fetches each pixel from a synchronous sprite ROM, or uses a solid colour in fill mode, and emits x/y/colour/plot to the adapter.
- Adds a start/busy/done handshake, screen clipping, transparent-colour skip and configurable ROM latency.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/pixel_delay_line.sv | 32 +++
 rtl/sprite_blitter.sv | 160 ++++++++++++++++
 tb/tb_sprite_blitter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA-path definitions: screen geometry defaults, colours and blitter enums.
package vga_pkg;

  localparam int unsigned SCREEN_W_DEF = 160;
  localparam int unsigned SCREEN_H_DEF = 120;
  localparam int unsigned COLOR_W_DEF  = 3;

  localparam logic [COLOR_W_DEF-1:0] COLOUR_BLACK = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DRAIN
  } blit_state_t;

  typedef enum logic {
    SPRITE,
    FILL
  } blit_mode_t;

endpackage

// File: rtl/pixel_delay_line.sv
// Fixed-depth shift register keeping pixel metadata aligned with the ROM read.
// The MSB of each word is its valid bit; o_any_valid reports an occupied stage.
module pixel_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_any_valid
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < int'(DEPTH); i++) r_stage[i] <= r_stage[i-1];
    end
  end

  always_comb begin
    o_any_valid = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) o_any_valid = o_any_valid | r_stage[i][WIDTH-1];
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/sprite_blitter.sv
// Rectangle drawer: walks an SPR_W x SPR_H region from a sync ROM or a solid colour,
// with screen clipping, transparent skip and a start/busy/done handshake.
module sprite_blitter
  import vga_pkg::*;
#(
  parameter int unsigned         X_W               = 8,
  parameter int unsigned         Y_W               = 7,
  parameter int unsigned         COLOR_W           = COLOR_W_DEF,
  parameter int unsigned         SPR_W             = 16,
  parameter int unsigned         SPR_H             = 16,
  parameter int unsigned         ADDR_W            = 8,
  parameter int unsigned         ROM_LATENCY       = 1,
  parameter int unsigned         SCREEN_W          = SCREEN_W_DEF,
  parameter int unsigned         SCREEN_H          = SCREEN_H_DEF,
  parameter bit                  TRANSPARENT_EN    = 1'b1,
  parameter logic [COLOR_W-1:0]  TRANSPARENT_COLOR = '0
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [COLOR_W-1:0] fill_colour,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_colour,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  localparam int unsigned SX_W   = X_W + 1;
  localparam int unsigned SY_W   = Y_W + 1;
  localparam int unsigned PIPE_W = 2 + X_W + Y_W;
  localparam logic [X_W-1:0] XC_LAST = X_W'(SPR_W - 1);
  localparam logic [Y_W-1:0] YC_LAST = Y_W'(SPR_H - 1);

  blit_state_t        r_state, w_state_next;
  blit_mode_t         r_mode;
  logic [X_W-1:0]     r_xc, r_x0, r_vga_x;
  logic [Y_W-1:0]     r_yc, r_y0, r_vga_y;
  logic [ADDR_W-1:0]  r_addr;
  logic [COLOR_W-1:0] r_fill, r_vga_colour;
  logic               r_busy, r_done, r_plot;

  logic               w_start_ok, w_last, w_pipe_busy, w_clip, w_trans, w_plot;
  logic [SX_W-1:0]    w_sx;
  logic [SY_W-1:0]    w_sy;
  logic [PIPE_W-1:0]  w_pipe_in, w_pipe_out;
  logic               w_d_valid, w_d_clip;
  logic [X_W-1:0]     w_d_x;
  logic [Y_W-1:0]     w_d_y;

  // A start landing on the done cycle is dropped; IDLE accepts from the next cycle.
  assign w_start_ok = (r_state == IDLE) && start && !r_done;
  assign w_last     = (r_xc == XC_LAST) && (r_yc == YC_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_start_ok)   w_state_next = DRAW;
      DRAW:    if (w_last)       w_state_next = DRAIN;
      DRAIN:   if (!w_pipe_busy) w_state_next = IDLE;
      default:                   w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_xc   <= '0;
      r_yc   <= '0;
      r_addr <= '0;
      r_x0   <= '0;
      r_y0   <= '0;
      r_mode <= SPRITE;
      r_fill <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == DRAIN) && !w_pipe_busy;
      if (w_start_ok) begin
        r_x0   <= x0;
        r_y0   <= y0;
        r_mode <= blit_mode_t'(mode);
        r_fill <= fill_colour;
        r_xc   <= '0;
        r_yc   <= '0;
        r_addr <= '0;
        r_busy <= 1'b1;
      end else if ((r_state == DRAW) && !w_last) begin
        r_addr <= r_addr + 1'b1;
        if (r_xc == XC_LAST) begin
          r_xc <= '0;
          r_yc <= r_yc + 1'b1;
        end else begin
          r_xc <= r_xc + 1'b1;
        end
      end
      if ((r_state == DRAIN) && !w_pipe_busy) r_busy <= 1'b0;
    end
  end

  // One bit wider than the screen coordinates so anchors near the edge cannot wrap.
  assign w_sx      = SX_W'(r_x0) + SX_W'(r_xc);
  assign w_sy      = SY_W'(r_y0) + SY_W'(r_yc);
  assign w_clip    = (w_sx >= SX_W'(SCREEN_W)) || (w_sy >= SY_W'(SCREEN_H));
  assign w_pipe_in = {r_state == DRAW, w_clip, w_sx[X_W-1:0], w_sy[Y_W-1:0]};

  pixel_delay_line #(
    .DEPTH (ROM_LATENCY),
    .WIDTH (PIPE_W)
  ) u_delay (
    .i_clk       (CLOCK_50),
    .i_clr       (reset),
    .i_data      (w_pipe_in),
    .o_data      (w_pipe_out),
    .o_any_valid (w_pipe_busy)
  );

  assign w_d_valid = w_pipe_out[PIPE_W-1];
  assign w_d_clip  = w_pipe_out[PIPE_W-2];
  assign w_d_x     = w_pipe_out[Y_W +: X_W];
  assign w_d_y     = w_pipe_out[0 +: Y_W];

  assign w_trans = TRANSPARENT_EN && (r_mode == SPRITE) && (rom_data == TRANSPARENT_COLOR);
  assign w_plot  = w_d_valid && !w_d_clip && !w_trans;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_plot       <= 1'b0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
    end else begin
      r_plot <= w_plot;
      if (w_plot) begin
        r_vga_x      <= w_d_x;
        r_vga_y      <= w_d_y;
        r_vga_colour <= (r_mode == FILL) ? r_fill : rom_data;
      end
    end
  end

  assign rom_addr   = r_addr;
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign plot       = r_plot;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench: three blitter configurations driven with random starts/resets,
// expected plots, busy and done derived from the rectangle-walk rules.
module tb_sprite_blitter;

  localparam int NI = 3;
  localparam int unsigned PW [NI] = '{4, 3, 1};
  localparam int unsigned PH [NI] = '{4, 2, 1};
  localparam int unsigned PL [NI] = '{1, 3, 2};
  localparam bit          PT [NI] = '{1'b1, 1'b0, 1'b0};

  typedef struct {
    int         edge_n;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input int j, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0d want=%0d at %0t", nm, j, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int W = int'(PW[g]);
    localparam int H = int'(PH[g]);
    localparam int L = int'(PL[g]);
    localparam int N = W * H;

    logic       rst, start, mode, plot, busy, done, fin;
    logic [2:0] fill, vc;
    logic [7:0] x0, addr, vx;
    logic [6:0] y0, vy;
    logic [2:0] mem [256];
    logic [2:0] rpipe [L];

    sprite_blitter #(
      .SPR_W          (PW[g]),
      .SPR_H          (PH[g]),
      .ROM_LATENCY    (PL[g]),
      .TRANSPARENT_EN (PT[g])
    ) u_dut (
      .CLOCK_50    (clk),
      .reset       (rst),
      .start       (start),
      .mode        (mode),
      .fill_colour (fill),
      .x0          (x0),
      .y0          (y0),
      .rom_addr    (addr),
      .rom_data    (rpipe[L-1]),
      .vga_x       (vx),
      .vga_y       (vy),
      .vga_colour  (vc),
      .plot        (plot),
      .busy        (busy),
      .done        (done)
    );

    // ROM model: L registered stages after the address is sampled.
    always @(posedge clk) begin
      rpipe[0] <= mem[addr];
      for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
    end

    int  cyc    = 0;
    bit  act    = 1'b0;
    int  acc_k  = 0;
    int  d_edge = -10;
    ev_t q[$];

    // Reference model, advanced on each edge from the bench's own stimulus.
    initial begin
      forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
          q.delete();
          act = 1'b0;
        end else if (start && (!act || cyc >= d_edge + 2)) begin
          act    = 1'b1;
          acc_k  = cyc;
          d_edge = cyc + N + L + 1;
          for (int i = 0; i < N; i++) begin
            int sx, sy;
            ev_t e;
            sx = int'(x0) + (i % W);
            sy = int'(y0) + (i / W);
            if (sx < 160 && sy < 120 && !(PT[g] && !mode && mem[i] == 3'd0)) begin
              e.edge_n = cyc + 1 + L + i;
              e.x      = 8'(sx);
              e.y      = 7'(sy);
              e.c      = mode ? fill : mem[i];
              q.push_back(e);
            end
          end
        end
      end
    end

    // Monitor: every cycle compares plot/busy/done and pops matching plot events.
    initial begin
      @(posedge clk);
      forever begin
        bit exp_plot;
        @(negedge clk);
        check("busy", g, int'(busy), int'(act && cyc >= acc_k && cyc < d_edge));
        check("done", g, int'(done), int'(act && cyc == d_edge));
        exp_plot = (q.size() > 0) && (q[0].edge_n == cyc);
        check("plot", g, int'(plot), int'(exp_plot));
        if (exp_plot) begin
          ev_t e;
          e = q.pop_front();
          if (plot) begin
            check("vga_x", g, int'(vx), int'(e.x));
            check("vga_y", g, int'(vy), int'(e.y));
            check("vga_colour", g, int'(vc), int'(e.c));
          end
        end
      end
    end

    initial begin
      fin = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = (i < 16 && g == 0) ? 3'(i % 8) : 3'($urandom_range(0, 7));
      mem[0] = 3'd0;
      rst = 1'b1; start = 1'b0; mode = 1'b0; fill = 3'd0; x0 = 8'd0; y0 = 7'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      // Directed: sprite at (10,20), then fill clipped at the bottom-right corner.
      start = 1'b1; x0 = 8'd10; y0 = 7'd20;
      @(negedge clk) start = 1'b0;
      repeat (N + L + 6) @(negedge clk);
      start = 1'b1; mode = 1'b1; fill = 3'b101; x0 = 8'd158; y0 = 7'd118;
      @(negedge clk) start = 1'b0;
      repeat (N + L + 6) @(negedge clk);
      // Directed: reset mid-draw, then a fresh draw.
      start = 1'b1; mode = 1'b0; x0 = 8'd5; y0 = 7'd7;
      @(negedge clk) start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      repeat (10) @(negedge clk);
      start = 1'b1; x0 = 8'd100; y0 = 7'd50;
      @(negedge clk) start = 1'b0;
      repeat (N + L + 6) @(negedge clk);
      for (int c = 0; c < 1500; c++) begin
        rst   = ($urandom_range(0, 299) == 0);
        start = ($urandom_range(0, 3) == 0);
        mode  = 1'($urandom_range(0, 1));
        fill  = 3'($urandom_range(0, 7));
        x0    = $urandom_range(0, 1) ? 8'($urandom_range(150, 255)) : 8'($urandom_range(0, 159));
        y0    = $urandom_range(0, 1) ? 7'($urandom_range(110, 127)) : 7'($urandom_range(0, 119));
        @(negedge clk);
      end
      rst = 1'b0; start = 1'b0;
      repeat (N + L + 10) @(negedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    int budget;
    budget = 0;
    while (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin) && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    checks++;
    if (budget >= 5000) begin
      failures++;
      $display("FAIL timeout stimulus not finished after %0d cycles (limit 5000)", budget);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
